hub75_framebuffer: RTL

Double-buffered 64×64, 1-bit-per-channel frame store that sits directly upstream of the HUB75 scan driver. It supplies the top-half and bottom-half RGB bits for a given line/column pair, which the driver shifts out on R1/G1/B1 and R2/G2/B2. A loader, such as a UART or SPI front end or a pattern generator, writes pixels into the hidden bank and requests a bank swap. The swap is applied only on a frame boundary signalled by the driver, so the panel never shows a torn frame. The block also provides a bulk clear of the hidden bank.

---
 rtl/hub75_framebuffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hub75_framebuffer.sv
// Double-buffered HUB75 frame store: two banks of top/bottom half RAMs.
// The loader writes or clears the hidden bank while the scan driver reads
// the displayed bank; bank swaps are deferred to a frame boundary so the
// panel never shows a torn frame.
module hub75_framebuffer #(
    parameter int COL_BITS  = 6,
    parameter int LINE_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [COL_BITS-1:0]  wr_x,
    input  logic [LINE_BITS:0]   wr_y,
    input  logic [2:0]           wr_rgb,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic                 swap_req,
    output logic                 swap_pending,
    output logic                 swap_ack,
    input  logic                 frame_start,
    input  logic                 rd_en,
    input  logic [LINE_BITS-1:0] rd_line,
    input  logic [COL_BITS-1:0]  rd_col,
    output logic [2:0]           rd_top,
    output logic [2:0]           rd_bot,
    output logic                 rd_valid,
    output logic                 disp_bank
);

    localparam int AW    = LINE_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_IDLE, S_PEND} swap_state_e;

    swap_state_e   state_q, state_d;
    logic          disp_bank_q, disp_bank_d;
    logic          swap_ack_q, swap_ack_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic [2:0]    rd_top_q, rd_bot_q;

    // Frame store: [bank][address], address = {line, col}. Not reset.
    logic [2:0] mem_top [2][DEPTH];
    logic [2:0] mem_bot [2][DEPTH];

    logic          hid_bank;
    logic          clr_start, wr_ok, swap_fire;
    logic          top_we, bot_we;
    logic [AW-1:0] waddr, raddr;
    logic [2:0]    wdata;

    // Next-state for clear sequencer, swap FSM and read-valid pipeline.
    always_comb begin
        hid_bank  = ~disp_bank_q;
        clr_start = clear_req && !busy_q;
        // A clear request in the same cycle wins over a pixel write.
        wr_ok     = wr_en && !busy_q && !clear_req;
        // A request arriving with the frame boundary is honoured immediately.
        swap_fire = frame_start && !busy_q && (state_q == S_PEND || swap_req);

        busy_d    = busy_q;
        clr_cnt_d = clr_cnt_q;
        if (busy_q) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (&clr_cnt_q) begin
                busy_d    = 1'b0;
                clr_cnt_d = '0;
            end
        end else if (clr_start) begin
            busy_d    = 1'b1;
            clr_cnt_d = '0;
        end

        state_d = state_q;
        if (swap_fire)
            state_d = S_IDLE;
        else if (swap_req)
            state_d = S_PEND;

        disp_bank_d = disp_bank_q ^ swap_fire;
        swap_ack_d  = swap_fire;
        rd_valid_d  = rd_en;
    end

    // RAM write port mux: the clear sweep owns both halves while busy.
    always_comb begin
        top_we = 1'b0;
        bot_we = 1'b0;
        waddr  = {wr_y[LINE_BITS-1:0], wr_x};
        wdata  = wr_rgb;
        raddr  = {rd_line, rd_col};
        if (!rst) begin
            if (busy_q) begin
                top_we = 1'b1;
                bot_we = 1'b1;
                waddr  = clr_cnt_q;
                wdata  = 3'b000;
            end else if (wr_ok) begin
                top_we = !wr_y[LINE_BITS];
                bot_we = wr_y[LINE_BITS];
            end
        end
    end

    // Hidden-bank writes (pixel or clear); contents survive reset.
    always_ff @(posedge clk) begin
        if (top_we)
            mem_top[hid_bank][waddr] <= wdata;
        if (bot_we)
            mem_bot[hid_bank][waddr] <= wdata;
    end

    // Synchronous read of the displayed bank; outputs hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_top_q <= 3'b000;
            rd_bot_q <= 3'b000;
        end else if (rd_en) begin
            rd_top_q <= mem_top[disp_bank_q][raddr];
            rd_bot_q <= mem_bot[disp_bank_q][raddr];
        end
    end

    // Control state: swap FSM, displayed bank, clear sequencer, read valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            disp_bank_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            clr_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_bank_q <= disp_bank_d;
            swap_ack_q  <= swap_ack_d;
            busy_q      <= busy_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign busy         = busy_q;
    assign swap_pending = (state_q == S_PEND);
    assign swap_ack     = swap_ack_q;
    assign disp_bank    = disp_bank_q;
    assign rd_valid     = rd_valid_q;
    assign rd_top       = rd_top_q;
    assign rd_bot       = rd_bot_q;

endmodule
